// File: rtl/rr_arb4_pkg.sv
// Shared definitions for the rr_arb4 round-robin arbiter: sizes, FSM encodings
// and the circular first-set-bit search used for arbitration.
package rr_arb4_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  // First set bit of v scanning upward from start with wraparound; returns start if v is zero.
  function automatic logic [IDX_W-1:0] rr_first(input logic [N_REQ-1:0] v,
                                                input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] idx;
    rr_first = start;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      idx = start + IDX_W'(k - 1);
      if (v[idx]) rr_first = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arb4_if.sv
// Requester-side bus of rr_arb4: requests and data bits in, grant/select/data out.
interface rr_arb4_if
  import rr_arb4_pkg::*;
#(
  parameter int unsigned CNT_W = 8
);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] w;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] sel;
  logic             busy;
  logic             y;
  logic [CNT_W-1:0] hold_cnt;

  modport master (
    output req, w,
    input  gnt, sel, busy, y, hold_cnt
  );

  modport slave (
    input  req, w,
    output gnt, sel, busy, y, hold_cnt
  );

endinterface

// File: rtl/rr_arb4_mux41.sv
// The team's 4:1 single-bit select mux.
module mux41 (
  input  logic [3:0] w,
  input  logic [1:0] s,
  output logic       f
);

  always_comb begin
    f = 1'b0;
    case (s)
      2'd0: f = w[0];
      2'd1: f = w[1];
      2'd2: f = w[2];
      2'd3: f = w[3];
      default: f = 1'b0;
    endcase
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-way round-robin arbiter with bounded hold time, steering one shared mux41
// so the granted requester's data bit reaches y.
module rr_arb4
  import rr_arb4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  rr_arb4_if.slave   bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  logic             state;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] sel_q;
  logic [N_REQ-1:0] gnt_q;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] winner;
  logic [N_REQ-1:0] winner_oh;
  logic             timed_out;
  logic             release_g;
  logic             mux_f;

  // last always equals the current owner while granted, so one search serves both states.
  always_comb begin
    winner    = rr_first(bus.req, last + IDX_W'(1));
    winner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << winner;
    timed_out = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    release_g = !bus.req[sel_q] || timed_out;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      gnt_q <= '0;
      sel_q <= '0;
      last  <= '1;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|bus.req) begin
            state <= ST_GRANT;
            gnt_q <= winner_oh;
            sel_q <= winner;
            last  <= winner;
            cnt   <= '0;
          end
        end
        ST_GRANT: begin
          if (!release_g) begin
            // Saturation only matters with the timeout disabled.
            if (cnt != '1) cnt <= cnt + CNT_W'(1);
          end else if (|bus.req) begin
            gnt_q <= winner_oh;
            sel_q <= winner;
            last  <= winner;
            cnt   <= '0;
          end else begin
            state <= ST_IDLE;
            gnt_q <= '0;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt_q <= '0;
          cnt   <= '0;
        end
      endcase
    end
  end

  mux41 u_mux (
    .w (bus.w),
    .s (sel_q),
    .f (mux_f)
  );

  assign bus.gnt      = gnt_q;
  assign bus.sel      = sel_q;
  assign bus.busy     = |gnt_q;
  assign bus.y        = (|gnt_q) & mux_f;
  assign bus.hold_cnt = cnt;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed test-plan sequences plus randomized
// traffic compared against an owner/last/count reference model.
module tb_rr_arb4;

  localparam int MH = 8;
  localparam int CW = 8;

  logic clk;
  logic reset;

  int checks;
  int failures;

  // Reference model state
  int m_owner;   // -1 when idle
  int m_last;
  int m_cnt;

  rr_arb4_if #(.CNT_W(CW)) bus ();

  rr_arb4 #(.MAX_HOLD(MH), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int from_last);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (from_last + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge(input logic rst, input logic [3:0] r);
    int p;
    if (rst) begin
      m_owner = -1;
      m_last  = 3;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      p = pick(r, m_last);
      if (p >= 0) begin
        m_owner = p;
        m_last  = p;
        m_cnt   = 0;
      end
    end else if (r[m_owner] && !(MH != 0 && m_cnt == MH - 1)) begin
      if (!(MH == 0 && m_cnt == (1 << CW) - 1)) m_cnt++;
    end else begin
      p = pick(r, m_last);
      m_owner = p;
      m_cnt   = 0;
      if (p >= 0) m_last = p;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] eg;
    logic       ey;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    ey = (m_owner < 0) ? 1'b0 : bus.w[m_owner];
    chk({tag, "_gnt"},  32'(bus.gnt),      32'(eg));
    chk({tag, "_busy"}, 32'(bus.busy),     32'(m_owner >= 0));
    chk({tag, "_y"},    32'(bus.y),        32'(ey));
    chk({tag, "_hold"}, 32'(bus.hold_cnt), 32'(m_cnt));
    if (m_owner >= 0) chk({tag, "_sel"}, 32'(bus.sel), 32'(m_owner));
  endtask

  // Drive inputs away from the edge, advance one clock, update the model, check.
  task automatic step(input string tag, input logic rst, input logic [3:0] r, input logic [3:0] wv);
    reset   = rst;
    bus.req = r;
    bus.w   = wv;
    @(posedge clk);
    model_edge(rst, r);
    #1;
    check_outputs(tag);
  endtask

  logic [3:0] rq;
  logic [3:0] wr;

  initial begin
    checks   = 0;
    failures = 0;
    m_owner  = -1;
    m_last   = 3;
    m_cnt    = 0;
    reset    = 1'b1;
    bus.req  = '0;
    bus.w    = '0;

    step("rst", 1'b1, 4'b0000, 4'b1111);
    step("rst", 1'b1, 4'b0000, 4'b1111);
    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_y",   32'(bus.y),   32'h0);

    for (int i = 0; i < 5; i++) begin
      step("idle", 1'b0, 4'b0000, 4'b1111);
      chk("idle_sel", 32'(bus.sel), 32'h0);
    end

    step("tp_0101", 1'b0, 4'b0101, 4'b0000);
    chk("tp_0101_gnt_const", 32'(bus.gnt), 32'b0001);
    step("tp_0100", 1'b0, 4'b0100, 4'b0000);
    chk("tp_handover_gnt_const", 32'(bus.gnt), 32'b0100);
    chk("tp_handover_sel_const", 32'(bus.sel), 32'd2);
    step("tp_drop", 1'b0, 4'b0000, 4'b0000);
    chk("tp_drop_gnt_const", 32'(bus.gnt), 32'b0000);

    for (int i = 0; i < 34; i++) step("rot", 1'b0, 4'b1111, 4'($urandom));

    step("solo_rst", 1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      step("solo", 1'b0, 4'b0010, 4'($urandom));
      chk("solo_gnt_const", 32'(bus.gnt), 32'b0010);
      chk("solo_hold_const", 32'(bus.hold_cnt), 32'(i % 8));
    end

    step("dp_rst", 1'b1, 4'b0000, 4'b1010);
    step("dp3", 1'b0, 4'b1000, 4'b1010);
    chk("dp_owner3_y_const", 32'(bus.y), 32'd1);
    step("dp2", 1'b0, 4'b0100, 4'b1010);
    chk("dp_owner2_y_const", 32'(bus.y), 32'd0);
    step("dpidle", 1'b0, 4'b0000, 4'b1010);
    chk("dp_idle_y_const", 32'(bus.y), 32'd0);

    step("mr_rst", 1'b1, 4'b0000, 4'b0000);
    step("mr_g", 1'b0, 4'b0010, 4'b0000);
    step("mr_g", 1'b0, 4'b0010, 4'b0000);
    step("mr_g", 1'b0, 4'b0010, 4'b0000);
    step("mr_rst2", 1'b1, 4'b0010, 4'b0000);
    chk("midreset_gnt_const", 32'(bus.gnt), 32'b0000);
    step("mr_rel", 1'b0, 4'b0010, 4'b0000);
    chk("midreset_regrant_const", 32'(bus.gnt), 32'b0010);

    // Random traffic: requests persist with occasional toggles, rare resets,
    // and w is also changed mid-cycle to exercise the combinational data path.
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
      step("rnd", ($urandom_range(0, 99) == 0), rq, 4'($urandom));
      wr = 4'($urandom);
      bus.w = wr;
      #1;
      chk("rnd_y_comb", 32'(bus.y), 32'((m_owner < 0) ? 1'b0 : wr[m_owner]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
